dlf_seq_ctrl: RTL

Sequencer and coefficient manager for the digital PLL core's decimator and loop-filter datapath. It brings the loop up in order: decimator warm-up, loop-filter acquisition, then tracking. It monitors the decimated phase error for lock and loss of lock. It double-buffers the four DLF coefficients so that regfile writes reach the filter only on a sample boundary. It sits between the regfile and the decimator and loop filter, and runs in the decimator clock domain.

---
 rtl/dlf_seq_pkg.sv | 11 +
 rtl/dlf_lock_det.sv | 44 ++++
 rtl/dlf_seq_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/dlf_seq_pkg.sv
// dlf_seq_pkg: shared types, widths and saturating shift for the DPLL loop sequencer
package dlf_seq_pkg;
    localparam int COEF_W = 16;
    localparam int ERR_W  = 15;
    typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, ACQ = 2'd2, TRACK = 2'd3} state_t;
    function automatic logic [COEF_W-1:0] sat_shl(input logic [COEF_W-1:0] v, input int sh);
        logic signed [2*COEF_W-1:0] w;
        w = $signed({{COEF_W{v[COEF_W-1]}}, v}) <<< sh;
        return (w > 32'sd32767) ? 16'h7fff : (w < -32'sd32768) ? 16'h8000 : w[COEF_W-1:0];
    endfunction
endpackage

// File: rtl/dlf_lock_det.sv
// dlf_lock_det: phase-error window compare with consecutive in/out-of-window counters
module dlf_lock_det import dlf_seq_pkg::*; #(
    parameter int               LOCK_CNT   = 64,
    parameter int               UNLOCK_CNT = 4,
    parameter logic [ERR_W-1:0] LOCK_THR   = 15'd64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sample_stb,
    input  logic             acq,
    input  logic             trk,
    input  logic             clr,
    input  logic [ERR_W-1:0] err_in,
    output logic             lock_hit,
    output logic             unlock_hit
);
    localparam int IW = $clog2(LOCK_CNT + 1);
    localparam int OW = $clog2(UNLOCK_CNT + 1);
    logic [IW-1:0]    in_cnt;
    logic [OW-1:0]    out_cnt;
    logic [ERR_W-1:0] mag;
    logic             in_win;
    // magnitude (most negative code saturates) and the hit strobes that complete a run
    always_comb begin
        mag        = !err_in[ERR_W-1] ? err_in :
                     (err_in == {1'b1, {(ERR_W-1){1'b0}}}) ? {1'b0, {(ERR_W-1){1'b1}}} : -err_in;
        in_win     = mag < LOCK_THR;
        lock_hit   = acq && sample_stb && in_win && in_cnt == IW'(LOCK_CNT - 1);
        unlock_hit = trk && sample_stb && !in_win && out_cnt == OW'(UNLOCK_CNT - 1);
    end
    // consecutive-sample counters, cleared whenever the sequencer changes state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (acq && sample_stb) in_cnt <= in_win ? in_cnt + 1'b1 : '0;
            if (trk && sample_stb) out_cnt <= in_win ? '0 : out_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dlf_seq_ctrl.sv
// dlf_seq_ctrl: DPLL loop bring-up FSM and DLF coefficient double buffer (option: DLF_GEARSHIFT_EN)
module dlf_seq_ctrl import dlf_seq_pkg::*; #(
    parameter int               WARM_CNT   = 16,
    parameter int               LOCK_CNT   = 64,
    parameter int               UNLOCK_CNT = 4,
    parameter logic [ERR_W-1:0] LOCK_THR   = 15'd64,
    parameter int               GEAR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              sample_stb,
    input  logic [ERR_W-1:0]  err_in,
    input  logic [COEF_W-1:0] a2_sh,
    input  logic [COEF_W-1:0] a3_sh,
    input  logic [COEF_W-1:0] b1_sh,
    input  logic [COEF_W-1:0] b2_sh,
    input  logic              coef_upd_req,
    output logic              dec_en,
    output logic              dlf_en,
    output logic [COEF_W-1:0] a2,
    output logic [COEF_W-1:0] a3,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic              coef_upd_done,
    output logic              locked,
    output logic [1:0]        state
);
    localparam int WW = $clog2(WARM_CNT + 1);
    state_t            st, st_nx;
    logic [WW-1:0]     warm_cnt;
    logic              lock_hit, unlock_hit, chg, apply, applied, pend;
    logic [COEF_W-1:0] pa2, pa3, pb1, pb2, ca2, ca3, cb1, cb2;
    assign state = st;
    dlf_lock_det #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .LOCK_THR(LOCK_THR)) u_lock (
        .clk        (clk),
        .rstn       (rstn),
        .sample_stb (sample_stb),
        .acq        (st == ACQ),
        .trk        (st == TRACK),
        .clr        (chg),
        .err_in     (err_in),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );
    // next state (start low wins) and the sample-boundary coefficient apply strobe
    always_comb begin
        st_nx = st;
        st_nx = !start ? IDLE :
                (st == IDLE) ? WARM :
                (st == WARM && sample_stb && warm_cnt == WW'(WARM_CNT - 1)) ? ACQ :
                (st == ACQ && lock_hit) ? TRACK :
                (st == TRACK && unlock_hit) ? ACQ : st;
        chg   = st_nx != st;
        apply = pend && !coef_upd_req && (st == IDLE || sample_stb);
    end
    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else       st <= st_nx;
    end
    // registered enables and warm-up sample counter; a strobe on the IDLE->WARM edge counts toward warm-up
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_en   <= 1'b0;
            dlf_en   <= 1'b0;
            locked   <= 1'b0;
            warm_cnt <= '0;
        end else begin
            dec_en   <= st_nx != IDLE;
            dlf_en   <= st_nx == ACQ || st_nx == TRACK;
            locked   <= st_nx == TRACK;
            warm_cnt <= chg ? WW'(st == IDLE && sample_stb) :
                        (st == WARM && sample_stb) ? warm_cnt + 1'b1 : warm_cnt;
        end
    end
    // coefficient double buffer: capture into pending, move to active on a sample boundary or in IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {pa2, pa3, pb1, pb2} <= '0;
            {ca2, ca3, cb1, cb2} <= '0;
            pend                 <= 1'b0;
            applied              <= 1'b0;
            coef_upd_done        <= 1'b0;
        end else begin
            if (coef_upd_req) {pa2, pa3, pb1, pb2} <= {a2_sh, a3_sh, b1_sh, b2_sh};
            if (apply) {ca2, ca3, cb1, cb2} <= {pa2, pa3, pb1, pb2};
            pend          <= coef_upd_req | (pend & ~apply);
            applied       <= apply;
            coef_upd_done <= applied;
        end
    end
    // active coefficients to the DLF, optionally boosted feedback gain during acquisition
    always_comb begin
        a2 = ca2;
        a3 = ca3;
`ifdef DLF_GEARSHIFT_EN
        b1 = (st == ACQ) ? sat_shl(cb1, GEAR_SHIFT) : cb1;
        b2 = (st == ACQ) ? sat_shl(cb2, GEAR_SHIFT) : cb2;
`else
        b1 = cb1;
        b2 = cb2;
`endif
    end
endmodule
